uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 208 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: 8N1 UART command parser driving a single-master req/ack bus.
// Commands: 'W' addr_hi addr_lo data -> write, reply ACK; 'R' addr_hi addr_lo -> read,
// reply with the read byte; anything else -> reply NAK.
module uart_bus_master #(
  parameter int unsigned BIT_CLKS     = 9236,
  parameter int unsigned TIMEOUT_CLKS = 20 * BIT_CLKS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_UART_TX,
  output logic        o_UART_RX,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic        o_RW,
  output logic        o_req,
  input  logic        i_ack,
  input  logic [7:0]  i_rdata,
  output logic        o_busy
);

  localparam int unsigned CntW = $clog2(BIT_CLKS);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CLKS - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CLKS / 2 - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;

  // ---------------------------------------------------------------- receiver
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rx_meta_q, rx_sync_q, rx_prev_q} <= 3'b111;
    else        {rx_meta_q, rx_sync_q, rx_prev_q} <= {i_UART_TX, rx_meta_q, rx_sync_q};
  end

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Receiver sequencing: midpoint sampling, glitch abort, framing-error lockout.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_valid_d = rx_sync_q;
        rx_state_d = rx_sync_q ? RxIdle : RxWaitHigh;
      end
      RxWaitHigh: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  logic [7:0] rx_byte;
  assign rx_byte = rx_shift_q;

  // ------------------------------------------------------------- transmitter
  logic            tx_start, tx_busy_q, tx_done;
  logic [9:0]      tx_shift_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [7:0]      resp_q;

  assign tx_done   = tx_busy_q && (tx_cnt_q == BitLast) && (tx_bit_q == 4'd9);
  assign o_UART_RX = tx_shift_q[0];

  // Frame shifter; ones shift in behind the stop bit so the line idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q  <= 1'b1;
        tx_shift_q <= {1'b1, resp_q, 1'b0};
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
      end
    end else if (tx_cnt_q == BitLast) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_bit_q   <= tx_bit_q + 1'b1;
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  // ------------------------------------------------------------------ parser
  typedef enum logic [2:0] {PIdle, PAh, PAl, PData, PBus, PResp} p_state_e;
  p_state_e       p_state_q, p_state_d;
  logic [ToW-1:0] to_cnt_q;
  logic           resp_loaded_q;
  logic           in_cmd, timed_out;

  assign in_cmd    = (p_state_q == PAh) || (p_state_q == PAl) || (p_state_q == PData);
  assign timed_out = (to_cnt_q == ToLast);

  // Parser state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p_state_q <= PIdle;
    else        p_state_q <= p_state_d;
  end

  // Parser next state; a valid byte always wins over a same-cycle timeout.
  always_comb begin
    p_state_d = p_state_q;
    unique case (p_state_q)
      PIdle: if (rx_valid_q) begin
        p_state_d = (rx_byte == CmdWrite || rx_byte == CmdRead) ? PAh : PResp;
      end
      PAh:   if (rx_valid_q) p_state_d = PAl;
             else if (timed_out) p_state_d = PIdle;
      PAl:   if (rx_valid_q) p_state_d = o_RW ? PBus : PData;
             else if (timed_out) p_state_d = PIdle;
      PData: if (rx_valid_q) p_state_d = PBus;
             else if (timed_out) p_state_d = PIdle;
      PBus:  if (i_ack) p_state_d = PResp;
      PResp: if (tx_done) p_state_d = PIdle;
      default: p_state_d = PIdle;
    endcase
  end

  // Parser outputs.
  always_comb begin
    o_busy   = (p_state_q != PIdle);
    o_req    = (p_state_q == PBus);
    tx_start = (p_state_q == PResp) && !resp_loaded_q;
  end

  // Command fields, response byte, inter-byte timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_addr        <= '0;
      o_wdata       <= '0;
      o_RW          <= 1'b1;
      resp_q        <= '0;
      resp_loaded_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      resp_loaded_q <= (p_state_q == PResp) && (p_state_d == PResp);
      to_cnt_q      <= (in_cmd && !rx_valid_q) ? to_cnt_q + 1'b1 : '0;
      if (rx_valid_q) begin
        case (p_state_q)
          PIdle: begin
            if (rx_byte == CmdWrite)     o_RW <= 1'b0;
            else if (rx_byte == CmdRead) o_RW <= 1'b1;
            else                         resp_q <= RespNak;
          end
          PAh:     o_addr[15:8] <= rx_byte;
          PAl:     o_addr[7:0]  <= rx_byte;
          PData:   o_wdata      <= rx_byte;
          default: ;
        endcase
      end
      if (p_state_q == PBus && i_ack) resp_q <= o_RW ? i_rdata : RespAck;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: table-driven and randomized command checks with a host-side UART
// receiver, a bus responder and a byte-level command model.
module tb_uart_bus_master;

  localparam int unsigned BitClks = 16;
  localparam int unsigned ToClks  = 320;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_tx = 1'b1;
  logic        ack = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        uart_rx, req, rw, busy;
  logic [15:0] addr;
  logic [7:0]  wdata;

  uart_bus_master #(
    .BIT_CLKS     (BitClks),
    .TIMEOUT_CLKS (ToClks)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_UART_TX (uart_tx),
    .o_UART_RX (uart_rx),
    .o_addr    (addr),
    .o_wdata   (wdata),
    .o_RW      (rw),
    .o_req     (req),
    .i_ack     (ack),
    .i_rdata   (rdata),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         req_pulses = 0;
  logic       req_prev = 1'b0;
  logic [7:0] host_q[$];

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    logic [7:0]      rd;
    int              dly;
    bit              exp_req;
    logic [15:0]     exp_addr;
    logic [7:0]      exp_wdata;
    bit              exp_rw;
    logic [7:0]      exp_resp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count rising edges of o_req.
  always @(negedge clk) begin
    req_prev <= req;
    if (req && !req_prev) req_pulses <= req_pulses + 1;
  end

  // Host-side UART receiver on o_UART_RX.
  initial begin : host_rx
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_rx) begin
        repeat (BitClks / 2) @(negedge clk);
        if (!uart_rx) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BitClks) @(negedge clk);
            b[i] = uart_rx;
          end
          repeat (BitClks) @(negedge clk);
          chk("host_stop_bit", uart_rx, 1);
          if (uart_rx) host_q.push_back(b);
        end
      end
      prev = uart_rx;
    end
  end

  initial begin : watchdog
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Send one 8N1 frame; a bad frame holds the stop bit low long enough to be sampled.
  task automatic uart_send(input logic [7:0] b, input logic stop, input int gap);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_tx = fr[i];
      if (i == 9 && !stop) repeat (BitClks * 3 / 4) @(negedge clk);
      else                 repeat (BitClks) @(negedge clk);
    end
    uart_tx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int n, input logic [7:0] rd,
                              input int dly, input bit er, input logic [15:0] ea,
                              input logic [7:0] ed, input bit erw, input logic [7:0] eresp);
    vec_t v;
    v.b = {b3, b2, b1, b0};
    v.n = n;  v.rd = rd;  v.dly = dly;
    v.exp_req = er;  v.exp_addr = ea;  v.exp_wdata = ed;  v.exp_rw = erw;  v.exp_resp = eresp;
    return v;
  endfunction

  // Reference: interpret the byte stream as a command.
  function automatic vec_t model(input vec_t v);
    logic [7:0] q[$];
    vec_t       r;
    r = v;
    for (int i = 0; i < v.n; i++) q.push_back(v.b[i]);
    r.exp_req = (q[0] == 8'h57) || (q[0] == 8'h52);
    r.exp_rw  = (q[0] == 8'h52);
    r.exp_addr = '0;  r.exp_wdata = '0;
    if (r.exp_req) r.exp_addr = {q[1], q[2]};
    if (r.exp_req && !r.exp_rw) r.exp_wdata = q[3];
    r.exp_resp = !r.exp_req ? 8'h15 : (r.exp_rw ? v.rd : 8'h06);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    int         kind;
    logic [7:0] c;
    logic [7:0] a1, a2, d, rd;
    kind = $urandom_range(0, 2);
    a1 = 8'($urandom);  a2 = 8'($urandom);  d = 8'($urandom);  rd = 8'($urandom);
    c = 8'($urandom_range(0, 255));
    if (c == 8'h57 || c == 8'h52) c = c ^ 8'h01;
    if (kind == 0)      c = 8'h57;
    else if (kind == 1) c = 8'h52;
    return mk(c, a1, a2, d, (kind == 0) ? 4 : (kind == 1) ? 3 : 1, rd,
              $urandom_range(0, 5), 0, 0, 0, 0, 0);
  endfunction

  task automatic run_cmd(input vec_t v);
    int base;
    bit got;
    base = req_pulses;
    fork
      begin
        for (int i = 0; i < v.n; i++) uart_send(v.b[i], 1'b1, 2 * BitClks);
      end
      begin
        if (v.exp_req) begin
          got = 1'b0;
          for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            got = req;
          end
          chk("req_seen", got, 1);
          if (got) begin
            chk("addr", addr, v.exp_addr);
            chk("rw", rw, v.exp_rw);
            if (!v.exp_rw) chk("wdata", wdata, v.exp_wdata);
            repeat (v.dly) @(negedge clk);
            chk("req_hold", req, 1);
            chk("addr_at_ack", addr, v.exp_addr);
            ack = 1'b1;
            rdata = v.rd;
            @(negedge clk);
            ack = 1'b0;
            rdata = 8'($urandom);
            chk("req_drop", req, 0);
          end
        end
      end
    join
    for (int i = 0; i < 600 && host_q.size() == 0; i++) @(negedge clk);
    chk("resp_count", host_q.size(), 1);
    if (host_q.size() > 0) begin
      chk("busy_in_stop", busy, 1);
      chk("resp_byte", host_q.pop_front(), v.exp_resp);
    end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("busy_end", busy, 0);
    chk("req_pulses", req_pulses - base, v.exp_req ? 1 : 0);
    repeat (BitClks * 12) @(negedge clk);
    chk("no_extra_resp", host_q.size(), 0);
  endtask

  initial begin : main
    vec_t tbl[$];
    int   base;

    repeat (3) @(negedge clk);
    chk("rst_uart_rx", uart_rx, 1);
    chk("rst_req", req, 0);
    chk("rst_rw", rw, 1);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    tbl.push_back(mk(8'h57, 8'h12, 8'h34, 8'hAB, 4, 8'h00, 3, 1, 16'h1234, 8'hAB, 0, 8'h06));
    tbl.push_back(mk(8'h52, 8'hC0, 8'h00, 8'h00, 3, 8'h5A, 1, 1, 16'hC000, 8'h00, 1, 8'h5A));
    tbl.push_back(mk(8'h41, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h15));
    for (int k = 0; k < 8; k++) tbl.push_back(model(rand_vec()));
    for (int k = 0; k < tbl.size(); k++) run_cmd(tbl[k]);

    // Spurious acknowledge while idle.
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_req", req, 0);

    // Inter-byte timeout abandons a partial write.
    base = req_pulses;
    uart_send(8'h57, 1'b1, 2 * BitClks);
    uart_send(8'h12, 1'b1, 2 * BitClks);
    repeat (100) @(negedge clk);
    chk("to_busy_early", busy, 1);
    repeat (300) @(negedge clk);
    chk("to_busy_late", busy, 0);
    chk("to_no_resp", host_q.size(), 0);
    run_cmd(mk(8'h52, 8'h00, 8'h10, 8'h00, 3, 8'hC3, 2, 1, 16'h0010, 8'h00, 1, 8'hC3));
    chk("to_req_total", req_pulses - base, 1);

    // Short low glitch must not start a byte.
    uart_tx = 1'b0;
    repeat (4) @(negedge clk);
    uart_tx = 1'b1;
    repeat (25 * BitClks) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_resp", host_q.size(), 0);

    // Framing error in idle is discarded.
    uart_send(8'h57, 1'b0, 2 * BitClks);
    chk("ferr_idle_busy", busy, 0);

    // Framing error mid-command neither advances the parser nor restarts the timeout.
    base = req_pulses;
    uart_send(8'h52, 1'b1, 0);
    uart_send(8'h00, 1'b1, 0);
    uart_send(8'h30, 1'b0, 2 * BitClks);
    repeat (200) @(negedge clk);
    chk("ferr_cmd_req", req_pulses - base, 0);
    chk("ferr_cmd_busy", busy, 0);
    chk("ferr_cmd_resp", host_q.size(), 0);

    // Reset while the bus request is pending.
    base = req_pulses;
    uart_send(8'h57, 1'b1, 2 * BitClks);
    uart_send(8'hAB, 1'b1, 2 * BitClks);
    uart_send(8'hCD, 1'b1, 2 * BitClks);
    uart_send(8'hEF, 1'b1, 2 * BitClks);
    chk("rst_mid_req_up", req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req_async", req, 0);
    chk("rst_mid_uart_rx", uart_rx, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    chk("rst_mid_no_resp", host_q.size(), 0);
    chk("rst_mid_busy_after", busy, 0);
    chk("rst_mid_one_req", req_pulses - base, 1);
    run_cmd(mk(8'h52, 8'h7E, 8'h01, 8'h00, 3, 8'h99, 0, 1, 16'h7E01, 8'h00, 1, 8'h99));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
